// File: rtl/prog_counter.sv
// Programmable up/down counter with modulo, prescaler, wrap/saturate, load, tc and sticky ovf.
// Optional compare output enabled by defining PROG_COUNTER_CMP_EN.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_flag,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  cmp_hit
);

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tc_q, tc_d;
  logic                  ovf_q, ovf_d;
  logic                  cmp_hit_q, cmp_hit_d;
  logic                  tick;
  logic                  wrap;

  always_comb begin
    count_d   = count_q;
    pre_cnt_d = pre_cnt_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    wrap      = 1'b0;
    tick      = en && (pre_cnt_q >= prescale);

    if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    end

    if (load) begin
      count_d   = (load_val > max_val) ? max_val : load_val;
      pre_cnt_d = '0;
    end else if (tick) begin
      // A bound lowered below the current count pulls the count back without a boundary event.
      if (count_q > max_val) begin
        count_d = max_val;
      end else if (up) begin
        if (count_q == max_val) begin
          tc_d = 1'b1;
          if (!sat) begin
            count_d = '0;
            wrap    = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (!sat) begin
            count_d = max_val;
            wrap    = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end

    if (wrap) begin
      ovf_d = 1'b1;
    end else if (clr_flag) begin
      ovf_d = 1'b0;
    end
  end

`ifdef PROG_COUNTER_CMP_EN
  always_comb begin
    cmp_hit_d = (count_q == cmp_val);
  end
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^cmp_val;

  always_comb begin
    cmp_hit_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      pre_cnt_q <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      cmp_hit_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      cmp_hit_q <= cmp_hit_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign cmp_hit = cmp_hit_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter; checks cmp_hit against PROG_COUNTER_CMP_EN.
module tb_prog_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       sat;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] max_val;
  logic [3:0] prescale;
  logic       clr_flag;
  logic [7:0] cmp_val;
  logic [7:0] count;
  logic       tc;
  logic       ovf;
  logic       cmp_hit;

  int errors = 0;
  int checks = 0;
  int exp_down_cnt[4] = '{1, 0, 0, 0};
  int exp_down_tc[4]  = '{0, 0, 1, 1};
  int prev_cnt;
  int exp_hit;

  prog_counter #(
    .WIDTH(8),
    .PRESCALE_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .up(up),
    .sat(sat),
    .load(load),
    .load_val(load_val),
    .max_val(max_val),
    .prescale(prescale),
    .clr_flag(clr_flag),
    .cmp_val(cmp_val),
    .count(count),
    .tc(tc),
    .ovf(ovf),
    .cmp_hit(cmp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
    load_val = 8'h00; max_val = 8'hFF; prescale = 4'd0; clr_flag = 1'b0; cmp_val = 8'h05;
    applyStimulus(2);
    checkOutput("reset_count", 32'(count), 32'h0);
    checkOutput("reset_tc", 32'(tc), 32'h0);
    checkOutput("reset_ovf", 32'(ovf), 32'h0);
    checkOutput("reset_cmp_hit", 32'(cmp_hit), 32'h0);

    // Async reset in the middle of a count.
    rst = 1'b0;
    load = 1'b1; load_val = 8'h37;
    applyStimulus(1);
    checkOutput("load_37", 32'(count), 32'h37);
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'h0);
    checkOutput("async_rst_tc", 32'(tc), 32'h0);
    checkOutput("async_rst_ovf", 32'(ovf), 32'h0);
    en = 1'b1; up = 1'b1; prescale = 4'd0; max_val = 8'hFF;
    #1 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1);
      checkOutput("post_rst_count", 32'(count), 32'(i));
    end

    // Wrap mode, modulo 10.
    max_val = 8'd9; sat = 1'b0; load = 1'b1; load_val = 8'd0;
    applyStimulus(1);
    checkOutput("wrap_load", 32'(count), 32'h0);
    load = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1);
      checkOutput("wrap_up_count", 32'(count), 32'(i));
      checkOutput("wrap_up_tc", 32'(tc), 32'h0);
    end
    applyStimulus(1);
    checkOutput("wrap_to_zero", 32'(count), 32'h0);
    checkOutput("wrap_tc", 32'(tc), 32'h1);
    checkOutput("wrap_ovf", 32'(ovf), 32'h1);
    applyStimulus(1);
    checkOutput("after_wrap_count", 32'(count), 32'h1);
    checkOutput("after_wrap_tc", 32'(tc), 32'h0);
    checkOutput("ovf_sticky", 32'(ovf), 32'h1);
    en = 1'b0; clr_flag = 1'b1;
    applyStimulus(1);
    clr_flag = 1'b0;
    checkOutput("clr_ovf", 32'(ovf), 32'h0);
    checkOutput("en_low_hold", 32'(count), 32'h1);

    // Saturating down count.
    en = 1'b1; up = 1'b0; sat = 1'b1; load = 1'b1; load_val = 8'd2;
    applyStimulus(1);
    load = 1'b0;
    checkOutput("sat_load", 32'(count), 32'h2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("sat_down_count", 32'(count), 32'(exp_down_cnt[i]));
      checkOutput("sat_down_tc", 32'(tc), 32'(exp_down_tc[i]));
    end
    checkOutput("sat_no_ovf", 32'(ovf), 32'h0);

    // Prescaler divide-by-4 with an enable gap mid-period.
    up = 1'b1; sat = 1'b0; max_val = 8'hFF; prescale = 4'd3; load = 1'b1; load_val = 8'd0;
    applyStimulus(1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("pre_wait", 32'(count), 32'h0);
    end
    applyStimulus(1);
    checkOutput("pre_tick1", 32'(count), 32'h1);
    applyStimulus(2);
    checkOutput("pre_mid", 32'(count), 32'h1);
    en = 1'b0;
    applyStimulus(5);
    checkOutput("pre_gap_hold", 32'(count), 32'h1);
    en = 1'b1;
    applyStimulus(1);
    checkOutput("pre_phase_wait", 32'(count), 32'h1);
    applyStimulus(1);
    checkOutput("pre_phase_tick", 32'(count), 32'h2);

    // Load clamp and lowered bound.
    prescale = 4'd0; load = 1'b1; load_val = 8'hF0; max_val = 8'h20;
    applyStimulus(1);
    load = 1'b0;
    checkOutput("load_clamp", 32'(count), 32'h20);
    max_val = 8'h10;
    applyStimulus(1);
    checkOutput("lower_max_count", 32'(count), 32'h10);
    checkOutput("lower_max_tc", 32'(tc), 32'h0);
    checkOutput("lower_max_ovf", 32'(ovf), 32'h0);
    applyStimulus(1);
    checkOutput("new_max_wrap", 32'(count), 32'h0);
    checkOutput("new_max_tc", 32'(tc), 32'h1);
    checkOutput("new_max_ovf", 32'(ovf), 32'h1);

    // max_val of zero with clr_flag held: set beats clear.
    max_val = 8'h00; up = 1'b0; clr_flag = 1'b1; load = 1'b1; load_val = 8'h00;
    applyStimulus(1);
    load = 1'b0;
    checkOutput("zero_load_clr", 32'(ovf), 32'h0);
    applyStimulus(1);
    checkOutput("zero_count", 32'(count), 32'h0);
    checkOutput("zero_tc", 32'(tc), 32'h1);
    checkOutput("set_beats_clr", 32'(ovf), 32'h1);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("zero_clr_ovf", 32'(ovf), 32'h0);
    checkOutput("zero_tc_drop", 32'(tc), 32'h0);
    clr_flag = 1'b0;

    // Compare output over a 0..9 sweep.
    en = 1'b1; up = 1'b1; max_val = 8'd9; cmp_val = 8'd5; load = 1'b1; load_val = 8'd0;
    applyStimulus(1);
    load = 1'b0;
    prev_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1);
      checkOutput("cmp_count", 32'(count), 32'(i % 10));
`ifdef PROG_COUNTER_CMP_EN
      exp_hit = (prev_cnt == 5) ? 1 : 0;
`else
      exp_hit = 0;
`endif
      checkOutput("cmp_hit", 32'(cmp_hit), 32'(exp_hit));
      prev_cnt = i % 10;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
